// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: parity modes, FSM encodings and
// the clocks-per-bit divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock receive FIFO with registered read port. A read on a non-empty
// FIFO presents the word and a one-cycle valid on the following cycle; a
// write while full is accepted only when a read frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers (wrap naturally at power-of-two depth), occupancy and read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// Parameterised UART: transmitter, receiver with glitch rejection and a
// receive FIFO with sticky error flags.
//
// TX handshake: a word moves on any rising edge where i_TX_Valid and
// o_TX_Ready are both high; o_TX_Ready is a pure function of TX state and
// never depends on i_TX_Valid, and i_TX_Data is only sampled on that edge.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 80000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 16
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic                      i_TX_Valid,
    input  logic [DATA_BITS-1:0]      i_TX_Data,
    output logic                      o_TX_Ready,
    output logic                      o_TX,
    input  logic                      i_RX,
    input  logic                      i_Read,
    output logic [DATA_BITS-1:0]      o_Data,
    output logic                      o_Data_Valid,
    output logic [$clog2(RX_DEPTH):0] o_RX_Count,
    output logic                      o_Frame_Err,
    output logic                      o_Parity_Err,
    output logic                      o_Overrun,
    input  logic                      i_Clear_Err,
    output logic [2:0]                o_TX_State,
    output logic [2:0]                o_RX_State
);

    localparam int DIV      = calc_div(CLK_HZ, BAUD);
    localparam int HALF     = DIV / 2;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN + 1);

    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] STOP_M1  = CW'(STOP_LEN - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic          PAR_INV  = (PARITY == PAR_ODD);

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_word, tx_word_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_line, tx_line_n;

    assign o_TX_Ready = (tx_state == TX_IDLE);
    assign o_TX       = tx_line;
    assign o_TX_State = tx_state;

    // TX state and datapath registers; reset leaves the line idle high.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_word  <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_word  <= tx_word_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
        end
    end

    // TX next state: each bit holds the registered line level for DIV clocks.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_word_n  = tx_word;
        tx_par_n   = tx_par;
        tx_line_n  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (i_TX_Valid) begin
                    tx_state_n = TX_START;
                    tx_word_n  = i_TX_Data;
                    tx_par_n   = (^i_TX_Data) ^ PAR_INV;
                    tx_bit_n   = '0;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == DIV_M1) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_line_n  = tx_word[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == DIV_M1) begin
                    tx_cnt_n = '0;
                    if (tx_bit == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            tx_state_n = TX_PARITY;
                            tx_line_n  = tx_par;
                        end else begin
                            tx_state_n = TX_STOP;
                            tx_line_n  = 1'b1;
                        end
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_line_n = tx_word[tx_bit + 3'd1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == DIV_M1) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == STOP_M1) begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = '0;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- RX
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_word, rx_word_n;
    logic                 rx_par_bad, rx_par_bad_n;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 set_frame, set_parity, set_overrun;
    logic                 fifo_wr, fifo_full, fifo_empty;

    assign o_RX_State = rx_state;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_word    <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_word    <= rx_word_n;
            rx_par_bad <= rx_par_bad_n;
        end
    end

    // RX next state: start re-checked at half a bit, later samples every DIV.
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt + CW'(1);
        rx_bit_n     = rx_bit;
        rx_word_n    = rx_word;
        rx_par_bad_n = rx_par_bad;
        set_frame    = 1'b0;
        set_parity   = 1'b0;
        set_overrun  = 1'b0;
        fifo_wr      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n   = RX_DATA;
                        rx_bit_n     = '0;
                        rx_par_bad_n = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_n          = '0;
                    rx_word_n[rx_bit] = rx_sync;
                    if (rx_bit == LAST_BIT) begin
                        rx_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_STOP;
                    if (rx_sync != ((^rx_word) ^ PAR_INV)) begin
                        rx_par_bad_n = 1'b1;
                        set_parity   = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_n = '0;
                    if (!rx_sync) begin
                        set_frame  = 1'b1;
                        rx_state_n = RX_WAIT_HIGH;
                    end else begin
                        rx_state_n = RX_IDLE;
                        if (!rx_par_bad) begin
                            if (!fifo_full || (i_Read && !fifo_empty)) begin
                                fifo_wr = 1'b1;
                            end else begin
                                set_overrun = 1'b1;
                            end
                        end
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_n = '0;
                if (rx_sync) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
                rx_cnt_n   = '0;
            end
        endcase
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Frame_Err  <= (o_Frame_Err  && !i_Clear_Err) || set_frame;
            o_Parity_Err <= (o_Parity_Err && !i_Clear_Err) || set_parity;
            o_Overrun    <= (o_Overrun    && !i_Clear_Err) || set_overrun;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clk      (i_Clock),
        .rst_n    (i_Reset_n),
        .wr       (fifo_wr),
        .wr_data  (rx_word),
        .rd       (i_Read),
        .rd_data  (o_Data),
        .rd_valid (o_Data_Valid),
        .count    (o_RX_Count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: four instances with different frame formats, checked
// against a bit-list frame model and an expected-data queue.
module tb_uart_cfg;

    // ------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ------------------------------------------------ per-instance signals
    // 0: defaults  1: odd parity, 2 stop  2: DIV=16 8N1  3: DIV=16 7E1
    logic       tx_valid [4];
    logic [7:0] tx_data  [4];
    logic       rx_drv   [4];
    logic       rd       [4];
    logic       clr      [4];
    logic       tx_ready [4];
    logic       tx_line  [4];
    logic [7:0] dout     [4];
    logic       dvalid   [4];
    logic [4:0] cnt      [4];
    logic       ferr     [4];
    logic       perr     [4];
    logic       ovr      [4];
    logic [2:0] txs      [4];
    logic [2:0] rxs      [4];
    logic [7:0] dout0, dout1, dout2;
    logic [6:0] dout3;
    logic       loop2;
    logic       rx_in2;

    assign dout[0] = dout0;
    assign dout[1] = dout1;
    assign dout[2] = dout2;
    assign dout[3] = {1'b0, dout3};
    assign rx_in2  = loop2 ? tx_line[2] : rx_drv[2];

    int div_c   [4] = '{694, 694, 16, 16};
    int nbits_c [4] = '{8, 8, 8, 7};
    int par_c   [4] = '{0, 2, 0, 1};
    int stop_c  [4] = '{1, 2, 1, 1};

    uart_cfg u_def (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_TX_Valid(tx_valid[0]), .i_TX_Data(tx_data[0]), .o_TX_Ready(tx_ready[0]), .o_TX(tx_line[0]),
        .i_RX(rx_drv[0]), .i_Read(rd[0]), .o_Data(dout0), .o_Data_Valid(dvalid[0]), .o_RX_Count(cnt[0]),
        .o_Frame_Err(ferr[0]), .o_Parity_Err(perr[0]), .o_Overrun(ovr[0]), .i_Clear_Err(clr[0]),
        .o_TX_State(txs[0]), .o_RX_State(rxs[0])
    );

    uart_cfg #(.PARITY(2), .STOP_BITS(2)) u_odd (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_TX_Valid(tx_valid[1]), .i_TX_Data(tx_data[1]), .o_TX_Ready(tx_ready[1]), .o_TX(tx_line[1]),
        .i_RX(rx_drv[1]), .i_Read(rd[1]), .o_Data(dout1), .o_Data_Valid(dvalid[1]), .o_RX_Count(cnt[1]),
        .o_Frame_Err(ferr[1]), .o_Parity_Err(perr[1]), .o_Overrun(ovr[1]), .i_Clear_Err(clr[1]),
        .o_TX_State(txs[1]), .o_RX_State(rxs[1])
    );

    uart_cfg #(.CLK_HZ(1600000), .BAUD(100000)) u_fast (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_TX_Valid(tx_valid[2]), .i_TX_Data(tx_data[2]), .o_TX_Ready(tx_ready[2]), .o_TX(tx_line[2]),
        .i_RX(rx_in2), .i_Read(rd[2]), .o_Data(dout2), .o_Data_Valid(dvalid[2]), .o_RX_Count(cnt[2]),
        .o_Frame_Err(ferr[2]), .o_Parity_Err(perr[2]), .o_Overrun(ovr[2]), .i_Clear_Err(clr[2]),
        .o_TX_State(txs[2]), .o_RX_State(rxs[2])
    );

    uart_cfg #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(1)) u_even7 (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_TX_Valid(tx_valid[3]), .i_TX_Data(tx_data[3][6:0]), .o_TX_Ready(tx_ready[3]), .o_TX(tx_line[3]),
        .i_RX(rx_drv[3]), .i_Read(rd[3]), .o_Data(dout3), .o_Data_Valid(dvalid[3]), .o_RX_Count(cnt[3]),
        .o_Frame_Err(ferr[3]), .o_Parity_Err(perr[3]), .o_Overrun(ovr[3]), .i_Clear_Err(clr[3]),
        .o_TX_State(txs[3]), .o_RX_State(rxs[3])
    );

    // ------------------------------------------------ scoreboard state
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       fbits[$];

    // Reference frame: start 0, data LSB first, optional parity, stop ones.
    function automatic void make_frame(input logic [7:0] data, input int nb, input int pm, input int sb);
        logic [7:0] mask;
        logic       p;
        mask = 8'((1 << nb) - 1);
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < nb; i++) fbits.push_back(data[i]);
        if (pm != 0) begin
            p = ^(data & mask);
            if (pm == 2) p = ~p;
            fbits.push_back(p);
        end
        for (int i = 0; i < sb; i++) fbits.push_back(1'b1);
    endfunction

    // ------------------------------------------------ driver tasks
    task automatic drive_rx(input int idx, input logic [7:0] data, input bit par_flip, input bit stop_bad);
        make_frame(data, nbits_c[idx], par_c[idx], 1);
        if (par_flip) fbits[nbits_c[idx] + 1] = ~fbits[nbits_c[idx] + 1];
        if (stop_bad) fbits[fbits.size() - 1] = 1'b0;
        for (int b = 0; b < fbits.size(); b++) begin
            rx_drv[idx] = fbits[b];
            repeat (div_c[idx]) @(negedge clk);
        end
        rx_drv[idx] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_err(input int idx);
        @(negedge clk);
        clr[idx] = 1'b1;
        @(negedge clk);
        clr[idx] = 1'b0;
    endtask

    task automatic read_check(input int idx, input logic [7:0] exp, input string name);
        @(negedge clk);
        rd[idx] = 1'b1;
        @(negedge clk);
        rd[idx] = 1'b0;
        checks++;
        if (dvalid[idx] !== 1'b1 || dout[idx] !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h", name, dvalid[idx], dout[idx], exp);
        end
        @(negedge clk);
        checks++;
        if (dvalid[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: valid=%b expected 0 on second cycle", name, dvalid[idx]);
        end
    endtask

    // Send one word and compare every clock of the line against the model.
    task automatic tx_send_check(input int idx, input logic [7:0] data, input string name);
        int guard;
        make_frame(data, nbits_c[idx], par_c[idx], stop_c[idx]);
        @(negedge clk);
        guard = 0;
        while (tx_ready[idx] !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tx_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b expected 1", name, tx_ready[idx]);
            return;
        end
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        for (int b = 0; b < fbits.size(); b++) begin
            logic want;
            logic seen;
            logic seen_rdy;
            bit   bad;
            want     = fbits[b];
            seen     = want;
            seen_rdy = 1'b0;
            bad      = 1'b0;
            for (int c = 0; c < div_c[idx]; c++) begin
                @(negedge clk);
                tx_valid[idx] = 1'b0;
                if (!bad && (tx_line[idx] !== want || tx_ready[idx] !== 1'b0)) begin
                    bad      = 1'b1;
                    seen     = tx_line[idx];
                    seen_rdy = tx_ready[idx];
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s_bit%0d: line=%b ready=%b expected line=%b ready=0", name, b, seen, seen_rdy, want);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_ready[idx] !== 1'b1 || tx_line[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: ready=%b line=%b expected 1 1", name, tx_ready[idx], tx_line[idx]);
        end
    endtask

    // ------------------------------------------------ tests
    task automatic check_idle(input int idx, input string name);
        checks++;
        if ({tx_line[idx], tx_ready[idx], dvalid[idx], ferr[idx], perr[idx], ovr[idx]} !== 6'b110000 ||
            cnt[idx] !== 5'd0 || dout[idx] !== 8'h00 || txs[idx] !== 3'd0 || rxs[idx] !== 3'd0) begin
            errors++;
            $display("FAIL %s%0d: tx=%b rdy=%b dv=%b fe=%b pe=%b ov=%b cnt=%0d data=%h txs=%0d rxs=%0d expected 1 1 0 0 0 0 0 00 0 0",
                     name, idx, tx_line[idx], tx_ready[idx], dvalid[idx], ferr[idx], perr[idx], ovr[idx],
                     cnt[idx], dout[idx], txs[idx], rxs[idx]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle(i, "reset_held");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle(i, "reset_released");
    endtask

    task automatic test_tx_default();
        tx_send_check(0, 8'hA5, "tx_a5_default");
    endtask

    task automatic test_tx_odd_two_stop();
        tx_send_check(1, 8'h03, "tx_03_odd_2stop");
    endtask

    task automatic test_rx_basic();
        drive_rx(2, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (cnt[2] !== 5'd1) begin
            errors++;
            $display("FAIL rx_5a_count: count=%0d expected 1", cnt[2]);
        end
        read_check(2, 8'h5A, "rx_5a_read");
        checks++;
        if (cnt[2] !== 5'd0) begin
            errors++;
            $display("FAIL rx_5a_count_after: count=%0d expected 0", cnt[2]);
        end
        @(negedge clk);
        rd[2] = 1'b1;
        @(negedge clk);
        rd[2] = 1'b0;
        checks++;
        if (dvalid[2] !== 1'b0 || dout[2] !== 8'h5A) begin
            errors++;
            $display("FAIL rx_empty_read: valid=%b data=%h expected valid=0 data=5a", dvalid[2], dout[2]);
        end
    endtask

    task automatic test_rx_glitch();
        rx_drv[0] = 1'b0;
        repeat (200) @(negedge clk);
        rx_drv[0] = 1'b1;
        rx_drv[2] = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv[2] = 1'b1;
        repeat (600) @(negedge clk);
        for (int i = 0; i < 3; i += 2) begin
            checks++;
            if (cnt[i] !== 5'd0 || ferr[i] !== 1'b0 || perr[i] !== 1'b0 || rxs[i] !== 3'd0) begin
                errors++;
                $display("FAIL rx_glitch%0d: count=%0d fe=%b pe=%b rxs=%0d expected 0 0 0 0", i, cnt[i], ferr[i], perr[i], rxs[i]);
            end
        end
    endtask

    task automatic test_frame_err();
        drive_rx(2, 8'h11, 1'b0, 1'b1);
        checks++;
        if (ferr[2] !== 1'b1 || cnt[2] !== 5'd0) begin
            errors++;
            $display("FAIL frame_err_set: fe=%b count=%0d expected 1 0", ferr[2], cnt[2]);
        end
        clear_err(2);
        @(negedge clk);
        checks++;
        if (ferr[2] !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: fe=%b expected 0", ferr[2]);
        end
        drive_rx(2, 8'hC3, 1'b0, 1'b0);
        read_check(2, 8'hC3, "frame_err_recover");
    endtask

    task automatic test_parity_err();
        drive_rx(3, 8'h2B, 1'b1, 1'b0);
        checks++;
        if (perr[3] !== 1'b1 || ferr[3] !== 1'b0 || cnt[3] !== 5'd0) begin
            errors++;
            $display("FAIL parity_err_set: pe=%b fe=%b count=%0d expected 1 0 0", perr[3], ferr[3], cnt[3]);
        end
        clear_err(3);
        drive_rx(3, 8'h2B, 1'b0, 1'b0);
        checks++;
        if (perr[3] !== 1'b0 || cnt[3] !== 5'd1) begin
            errors++;
            $display("FAIL parity_good: pe=%b count=%0d expected 0 1", perr[3], cnt[3]);
        end
        read_check(3, 8'h2B, "parity_good_read");
    endtask

    task automatic test_overrun();
        exp_q.delete();
        for (int f = 0; f < 17; f++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            if (f < 16) exp_q.push_back(d);
            drive_rx(2, d, 1'b0, 1'b0);
        end
        checks++;
        if (cnt[2] !== 5'd16 || ovr[2] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_full: count=%0d ov=%b expected 16 1", cnt[2], ovr[2]);
        end
        for (int f = 0; f < 16; f++) read_check(2, exp_q.pop_front(), "overrun_drain");
        checks++;
        if (cnt[2] !== 5'd0) begin
            errors++;
            $display("FAIL overrun_empty: count=%0d expected 0", cnt[2]);
        end
        clear_err(2);
    endtask

    task automatic test_rx_random();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 127));
            exp_q.push_back(d);
            drive_rx(3, d, 1'b0, 1'b0);
        end
        checks++;
        if (cnt[3] !== 5'd6 || perr[3] !== 1'b0) begin
            errors++;
            $display("FAIL rx_random_count: count=%0d pe=%b expected 6 0", cnt[3], perr[3]);
        end
        while (exp_q.size() > 0) read_check(3, exp_q.pop_front(), "rx_random_read");
    endtask

    task automatic test_loopback();
        loop2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            tx_send_check(2, d, "loop_tx");
            repeat (2) @(negedge clk);
            checks++;
            if (cnt[2] !== 5'd1) begin
                errors++;
                $display("FAIL loop_count: count=%0d expected 1", cnt[2]);
            end
            read_check(2, d, "loop_read");
        end
        loop2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            tx_send_check(3, 8'($urandom_range(0, 127)), "b2b_tx7e1");
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        tx_data[2]  = 8'h00;
        tx_valid[2] = 1'b1;
        @(negedge clk);
        tx_valid[2] = 1'b0;
        rx_drv[3]   = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (tx_line[2] !== 1'b0 || tx_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL midframe_active: line=%b ready=%b expected 0 0", tx_line[2], tx_ready[2]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_line[2] !== 1'b1 || tx_ready[2] !== 1'b1 || txs[2] !== 3'd0 || rxs[3] !== 3'd0) begin
            errors++;
            $display("FAIL midframe_async_reset: line=%b ready=%b txs=%0d rxs=%0d expected 1 1 0 0",
                     tx_line[2], tx_ready[2], txs[2], rxs[3]);
        end
        rx_drv[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (cnt[3] !== 5'd0 || ferr[3] !== 1'b0 || perr[3] !== 1'b0 || tx_line[2] !== 1'b1 || tx_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_after: count=%0d fe=%b pe=%b line=%b ready=%b expected 0 0 0 1 1",
                     cnt[3], ferr[3], perr[3], tx_line[2], tx_ready[2]);
        end
    endtask

    // ------------------------------------------------ sequence and report
    initial begin
        rst_n = 1'b0;
        loop2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
            rx_drv[i]   = 1'b1;
            rd[i]       = 1'b0;
            clr[i]      = 1'b0;
        end
        test_reset();
        test_tx_default();
        test_tx_odd_two_stop();
        test_rx_basic();
        test_rx_glitch();
        test_frame_err();
        test_parity_err();
        test_overrun();
        test_rx_random();
        test_loopback();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter CLK_HZ, 80000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line rate; DIV = round(CLK_HZ/BAUD) clocks per bit (694 at defaults).
REQ-003 Parameter DATA_BITS, 8, frame data bits; legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits transmitted; legal values 1 or 2.
REQ-006 Parameter RX_DEPTH, 16, receive FIFO entries; power of two, minimum 2.
REQ-007 Port i_Clock, input, 1, the single clock; all logic is on its rising edge.
REQ-008 Port i_Reset_n, input, 1, asynchronous active-low reset.
REQ-009 Port i_TX_Valid, input, 1, transmit request.
REQ-010 Port i_TX_Data, input, DATA_BITS, transmit word.
REQ-011 Port o_TX_Ready, output, 1, transmitter idle and accepting.
REQ-012 Port o_TX, output, 1, serial line out, idle high.
REQ-013 Port i_RX, input, 1, asynchronous serial line in.
REQ-014 Port i_Read, input, 1, pop request for the receive FIFO.
REQ-015 Port o_Data, output, DATA_BITS, popped word.
REQ-016 Port o_Data_Valid, output, 1, one-cycle pulse marking o_Data valid.
REQ-017 Port o_RX_Count, output, clog2(RX_DEPTH)+1, FIFO occupancy.
REQ-018 Port o_Frame_Err / o_Parity_Err / o_Overrun, output, 1 each, sticky error flags.
REQ-019 Port i_Clear_Err, input, 1, clears all three sticky flags.

Function
REQ-020 TX handshake: transfer when i_TX_Valid && o_TX_Ready; o_TX_Ready is high only in TX IDLE.
REQ-021 TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE; every bit lasts exactly DIV clocks.
REQ-022 o_TX drives low on the cycle after transfer; data LSB first; STOP is STOP_BITS*DIV clocks high; o_TX_Ready rises after the final stop clock.
REQ-023 Parity bit: even = XOR of data bits; odd = its inverse.
REQ-024 RX input passes a 2-flop synchroniser; all RX timing is measured from the synchronised signal.
REQ-025 RX FSM: IDLE -> START on synchronised high-to-low; START re-samples at DIV/2; if high, return to IDLE with no error (glitch rejection).
REQ-026 DATA, PARITY and STOP are each sampled DIV clocks after the previous sample, i.e. at bit centre; only one stop bit is checked.
REQ-027 Stop sampled low: set o_Frame_Err, discard word, wait for line high before IDLE.
REQ-028 Parity mismatch: set o_Parity_Err, discard word.
REQ-029 Good word with FIFO not full: write on the stop-sample cycle.
REQ-030 Good word with FIFO full: set o_Overrun, drop the word, leave FIFO contents unchanged.
REQ-031 Write while full with simultaneous i_Read: both proceed, no overrun.
REQ-032 i_Read with count>0: o_Data and o_Data_Valid are presented the next cycle; the valid pulse lasts one cycle.
REQ-033 i_Read with count=0: ignored, no pulse; o_Data holds its last value.
REQ-034 Pointers wrap modulo RX_DEPTH; o_RX_Count ranges 0..RX_DEPTH and is unchanged on simultaneous read+write.
REQ-035 Error set and i_Clear_Err in the same cycle: the flag ends set.

Reset
REQ-036 On i_Reset_n low, immediately: o_TX=1, o_TX_Ready=1, both FSMs IDLE, FIFO empty, o_RX_Count=0, o_Data=0, o_Data_Valid=0, all error flags 0, synchroniser flops 1.
REQ-037 Reset mid-frame aborts the frame; a partial RX word is not written and the TX word is lost.

Structure
REQ-038 Shared package uart_pkg holds parity-mode constants, TX/RX state encodings and the DIV computation function.
REQ-039 The receive FIFO is sub-module uart_sync_fifo (parameters WIDTH, DEPTH), providing count, full and empty.

Verification
REQ-040 Defaults; send 0xA5 -> o_TX low 694 clks, then bits 1,0,1,0,0,1,0,1 of 694 clks each, high 694 clks, then o_TX_Ready=1.
REQ-041 PARITY=2, STOP_BITS=2, send 0x03 -> parity bit 1, stop high for 1388 clks.
REQ-042 i_RX driven with 0x5A frame, then i_Read -> o_Data=0x5A, o_Data_Valid one cycle, o_RX_Count 1->0.
REQ-043 i_RX low pulse of 200 clks -> no word, no error, count 0.
REQ-044 0x11 frame with low stop bit -> o_Frame_Err=1, count 0; i_Clear_Err -> 0.
REQ-045 17 good frames without reads -> count 16, o_Overrun=1; 16 reads return frames 1..16 in order.
